// File: rtl/imem_refill_if.sv
// Bus between the instruction cache, the refill engine and main memory.
// The cache side is the master and the refill engine is the slave.
// Handshake: a read beat completes on any cycle where omem_rd and imem_ack
// are both high; omem_addr holds until then. oline_valid is a one-cycle
// pulse with no back-pressure, qualified by oerr.
interface imem_refill_if;
    logic         ireq;
    logic [31:0]  ireq_addr;
    logic         obusy;
    logic         omem_rd;
    logic [31:0]  omem_addr;
    logic [31:0]  imem_rdata;
    logic         imem_ack;
    logic [127:0] oline;
    logic [31:0]  oline_addr;
    logic         oline_valid;
    logic         oerr;

    modport master (
        output ireq, ireq_addr, imem_rdata, imem_ack,
        input  obusy, omem_rd, omem_addr, oline, oline_addr, oline_valid, oerr
    );

    modport slave (
        input  ireq, ireq_addr, imem_rdata, imem_ack,
        output obusy, omem_rd, omem_addr, oline, oline_addr, oline_valid, oerr
    );
endinterface

// File: rtl/imem_refill.sv
// Instruction cache line refill: four word reads, critical word first,
// with a per-beat ack timeout that aborts the refill with an error pulse.
module imem_refill #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    imem_refill_if.slave bus,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // A beat times out on the TIMEOUT-th cycle without ack; an ack on that cycle still wins.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t       cur;
    state_t       nxt;
    logic [27:0]  base_hi;
    logic [1:0]   beat;
    logic [1:0]   n_done;
    logic [7:0]   wait_cnt;
    logic [127:0] line_q;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (rstn) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: begin
                if (bus.ireq) begin
                    nxt = READ;
                end
            end
            READ: begin
                if (bus.imem_ack) begin
                    if (n_done == 2'd3) begin
                        nxt = DONE;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt = ERR;
                end
            end
            DONE:    nxt = IDLE;
            ERR:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            base_hi  <= '0;
            beat     <= '0;
            n_done   <= '0;
            wait_cnt <= '0;
            line_q   <= '0;
        end else begin
            case (cur)
                IDLE: begin
                    if (bus.ireq) begin
                        base_hi  <= bus.ireq_addr[31:4];
                        beat     <= bus.ireq_addr[3:2];
                        n_done   <= '0;
                        wait_cnt <= '0;
                    end
                end
                READ: begin
                    if (bus.imem_ack) begin
                        // Words land at their address slot, not in arrival order.
                        line_q[{beat, 5'b00000} +: 32] <= bus.imem_rdata;
                        beat     <= beat + 2'd1;
                        n_done   <= n_done + 2'd1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.obusy       = (cur != IDLE);
        bus.omem_rd     = (cur == READ);
        bus.oline_valid = (cur == DONE) || (cur == ERR);
        bus.oerr        = (cur == ERR);
        // The beat index replaces bits [3:2] so the address never leaves the line.
        bus.omem_addr   = {base_hi, beat, 2'b00};
        bus.oline       = line_q;
        bus.oline_addr  = {base_hi, 4'b0000};
    end

endmodule

// File: tb/tb_imem_refill.sv
// Directed bench for imem_refill: a memory responder with per-beat stalls,
// plus scoreboard queues for read addresses and delivered lines.
module tb_imem_refill;

    logic       clk;
    logic       rstn;
    logic [1:0] state;

    imem_refill_if bus ();

    imem_refill #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .state (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_pass;
    logic [31:0]  exp_addr_q[$];
    logic [161:0] exp_line_q[$];   // {check_line, err, line_addr, line}

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [127:0] line, input logic [31:0] addr,
                             input logic err, input logic chk_line);
        exp_line_q.push_back({chk_line, err, addr, line});
    endtask

    // ---------------- memory responder ----------------
    int          hold[4];   // no-ack cycles before each beat's ack, by arrival order; -1 = never
    logic [31:0] dbase;
    logic        spurious;
    int          beat_i;
    int          wait_i;
    bit          in_read;

    always @(posedge clk) begin
        #1;
        if (!bus.omem_rd) begin
            beat_i         = 0;
            wait_i         = 0;
            in_read        = 1'b0;
            bus.imem_ack   = spurious;
            bus.imem_rdata = spurious ? 32'hDEAD_BEEF : 32'h0;
        end else begin
            if (in_read) begin
                if (bus.imem_ack) begin
                    beat_i++;
                    wait_i = 0;
                end else begin
                    wait_i++;
                end
            end
            in_read = 1'b1;
            if (beat_i < 4 && hold[beat_i] >= 0 && wait_i >= hold[beat_i]) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = dbase + {30'b0, bus.omem_addr[3:2]};
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'h0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [31:0]  ea;
        logic [161:0] el;
        if (bus.omem_rd && bus.imem_ack) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_read_beat", 1'b1, 1'b0);
            end else begin
                ea = exp_addr_q.pop_front();
                check("omem_addr", bus.omem_addr, ea);
            end
        end
        if (bus.oline_valid) begin
            if (exp_line_q.size() == 0) begin
                check("unexpected_oline_valid", 1'b1, 1'b0);
            end else begin
                el = exp_line_q.pop_front();
                check("oline_addr", bus.oline_addr, el[159:128]);
                check("oerr", bus.oerr, el[160]);
                if (el[161]) check("oline", bus.oline, el[127:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic start_req(input logic [31:0] addr);
        bus.ireq      = 1'b1;
        bus.ireq_addr = addr;
        @(negedge clk);
        bus.ireq      = 1'b0;
        bus.ireq_addr = 32'h0;
    endtask

    // Returns at the negedge of the oline_valid cycle; cyc counts refill cycles.
    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!bus.oline_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.oline_valid) check("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic push_addrs(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
        exp_addr_q.push_back(a0);
        exp_addr_q.push_back(a1);
        exp_addr_q.push_back(a2);
        exp_addr_q.push_back(a3);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cyc;
        n_checks       = 0;
        n_pass         = 0;
        rstn           = 1'b1;
        bus.ireq       = 1'b0;
        bus.ireq_addr  = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        spurious       = 1'b0;
        dbase          = 32'h0;
        hold           = '{0, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_obusy", bus.obusy, 1'b0);
        check("rst_omem_rd", bus.omem_rd, 1'b0);
        check("rst_valid", bus.oline_valid, 1'b0);
        check("rst_oerr", bus.oerr, 1'b0);
        check("rst_oline", bus.oline, 128'h0);
        check("rst_oline_addr", bus.oline_addr, 32'h0);
        check("rst_omem_addr", bus.omem_addr, 32'h0);
        check("rst_state", state, 2'd0);
        rstn = 1'b0;
        @(negedge clk);

        // Aligned miss, zero-wait memory.
        dbase = 32'hA0;
        push_addrs(32'h1000, 32'h1004, 32'h1008, 32'h100C);
        push_line(128'h000000A3_000000A2_000000A1_000000A0, 32'h1000, 1'b0, 1'b1);
        start_req(32'h0000_1000);
        wait_valid(1, cyc);
        check("latency_aligned", cyc, 5);
        @(negedge clk);
        check("pulse_one_cycle", bus.oline_valid, 1'b0);
        check("idle_after_done", bus.obusy, 1'b0);

        // Acks while no read is outstanding must not touch the line.
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        spurious = 1'b0;
        check("stray_ack_line", bus.oline, 128'h000000A3_000000A2_000000A1_000000A0);
        check("stray_ack_state", state, 2'd0);

        // Critical word in slot 2: wrap order, placement by address.
        dbase = 32'hB0;
        push_addrs(32'h2008, 32'h200C, 32'h2000, 32'h2004);
        push_line(128'h000000B3_000000B2_000000B1_000000B0, 32'h2000, 1'b0, 1'b1);
        start_req(32'h0000_2008);
        wait_valid(1, cyc);
        check("latency_wrap", cyc, 5);
        @(negedge clk);

        // Ack on the last allowed wait cycle of beat 1 completes normally.
        hold  = '{0, 3, 0, 0};
        dbase = 32'hC0;
        push_addrs(32'h3004, 32'h3008, 32'h300C, 32'h3000);
        push_line(128'h000000C3_000000C2_000000C1_000000C0, 32'h3000, 1'b0, 1'b1);
        start_req(32'h0000_3004);
        wait_valid(1, cyc);
        check("latency_late_ack", cyc, 8);
        @(negedge clk);

        // No ack on beat 2: four wait cycles, then the error pulse.
        hold  = '{0, 0, -1, 0};
        dbase = 32'hD0;
        exp_addr_q.push_back(32'h4000);
        exp_addr_q.push_back(32'h4004);
        push_line(128'h0, 32'h4000, 1'b1, 1'b0);
        start_req(32'h0000_4000);
        wait_valid(1, cyc);
        check("latency_timeout", cyc, 7);
        check("err_omem_rd", bus.omem_rd, 1'b0);
        check("err_state", state, 2'd3);
        @(negedge clk);
        check("after_err_obusy", bus.obusy, 1'b0);
        check("after_err_valid", bus.oline_valid, 1'b0);
        check("after_err_omem_rd", bus.omem_rd, 1'b0);

        // A second request mid-refill is dropped.
        hold  = '{0, 0, 0, 0};
        dbase = 32'hE0;
        push_addrs(32'h5000, 32'h5004, 32'h5008, 32'h500C);
        push_line(128'h000000E3_000000E2_000000E1_000000E0, 32'h5000, 1'b0, 1'b1);
        start_req(32'h0000_5000);
        bus.ireq      = 1'b1;
        bus.ireq_addr = 32'h0000_6000;
        @(negedge clk);
        bus.ireq      = 1'b0;
        bus.ireq_addr = 32'h0;
        wait_valid(2, cyc);
        check("latency_ignored_req", cyc, 5);

        // Request raised in the DONE cycle waits for IDLE, then reset aborts it.
        dbase         = 32'hF0;
        bus.ireq      = 1'b1;
        bus.ireq_addr = 32'h0000_7000;
        exp_addr_q.push_back(32'h7000);
        exp_addr_q.push_back(32'h7004);
        exp_addr_q.push_back(32'h7008);
        @(negedge clk);
        check("req_in_done_ignored", bus.obusy, 1'b0);
        @(negedge clk);
        check("req_accepted_in_idle", bus.obusy, 1'b1);
        bus.ireq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn          = 1'b1;
        bus.ireq      = 1'b1;
        bus.ireq_addr = 32'h0000_8000;
        @(negedge clk);
        check("abort_obusy", bus.obusy, 1'b0);
        check("abort_omem_rd", bus.omem_rd, 1'b0);
        check("abort_valid", bus.oline_valid, 1'b0);
        check("abort_oerr", bus.oerr, 1'b0);
        check("abort_oline", bus.oline, 128'h0);
        check("abort_oline_addr", bus.oline_addr, 32'h0);
        check("abort_omem_addr", bus.omem_addr, 32'h0);
        check("abort_state", state, 2'd0);

        // Request held through reset is taken on the first edge out of reset.
        rstn  = 1'b0;
        dbase = 32'h90;
        push_addrs(32'h8000, 32'h8004, 32'h8008, 32'h800C);
        push_line(128'h00000093_00000092_00000091_00000090, 32'h8000, 1'b0, 1'b1);
        @(negedge clk);
        check("accept_after_reset", bus.obusy, 1'b1);
        bus.ireq      = 1'b0;
        bus.ireq_addr = 32'h0;
        wait_valid(1, cyc);
        check("latency_after_reset", cyc, 5);
        @(negedge clk);

        check("addr_queue_drained", exp_addr_q.size(), 0);
        check("line_queue_drained", exp_line_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_refill.md
IMEM_REFILL -- requirements
Module: imem_refill

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles waited for imem_ack per beat (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 ireq  input  1  cache miss request; level, sampled only in IDLE.
REQ-005 ireq_addr  input  32  miss address (byte address of missing instruction).
REQ-006 obusy  output  1  high in every state except IDLE.
REQ-007 omem_rd  output  1  word read strobe to main memory.
REQ-008 omem_addr  output  32  word address of current beat, bits[1:0]=0.
REQ-009 imem_rdata  input  32  read data, valid when imem_ack=1.
REQ-010 imem_ack  input  1  memory completes current read this cycle.
REQ-011 oline  output  128  assembled line to instruction cache (feeds cache imem_in).
REQ-012 oline_addr  output  32  line base address, bits[3:0]=0.
REQ-013 oline_valid  output  1  one-cycle pulse: oline/oline_addr/oerr valid.
REQ-014 oerr  output  1  qualifies oline_valid; 1 = refill aborted by timeout.

Function
REQ-015 FSM states SHALL be IDLE, READ, DONE, ERR.
REQ-016 IDLE: on ireq=1, latch base={ireq_addr[31:4],4'b0}, start beat b0=ireq_addr[3:2], beat counter n=0, wait counter=0, go READ.
REQ-017 READ: omem_rd=1, omem_addr=base+{b,2'b00}, b = current beat index; omem_addr stable until ack.
REQ-018 On imem_ack=1 in READ: write imem_rdata into oline[32*b+31:32*b], b=(b+1) mod 4 (3 wraps to 0), n=n+1, wait counter cleared.
REQ-019 Fourth ack (n==3 at ack) SHALL transition to DONE; critical word fetched first.
REQ-020 imem_ack while omem_rd=0 SHALL be ignored.
REQ-021 Wait counter increments each READ cycle without ack; reaching TIMEOUT with no ack -> ERR.
REQ-022 Ack in the same cycle counter reaches TIMEOUT: ack wins, no error.
REQ-023 DONE: oline_valid=1, oerr=0 for exactly one cycle, then IDLE.
REQ-024 ERR: oline_valid=1, oerr=1 for exactly one cycle, then IDLE; oline contents undefined-but-stable.
REQ-025 omem_rd=0 in IDLE, DONE, ERR.
REQ-026 ireq while obusy=1 (incl. DONE/ERR cycle) SHALL be ignored; earliest acceptance is the first IDLE cycle.
REQ-027 oline and oline_addr SHALL hold last values until next accepted request overwrites them.
REQ-028 Minimum latency, zero-wait memory: ireq sampled at edge E0 -> omem_rd high cycles 1-4 -> oline_valid high cycle 5.
REQ-029 omem_addr arithmetic SHALL stay inside the 16-byte line (no carry into bit 4).

Reset
REQ-030 rstn=1 at an edge SHALL force IDLE, clear beat/wait counters; obusy, omem_rd, oline_valid, oerr =0; oline, oline_addr, omem_addr =0.
REQ-031 Reset mid-refill SHALL abort with no oline_valid pulse; omem_rd low from the cycle after the reset edge.
REQ-032 ireq held high during and after reset SHALL be accepted on the first edge with rstn=0.

Verification
REQ-033 ireq_addr=0x0000_1000, zero-wait memory returning 0xA0,0xA1,0xA2,0xA3 -> omem_addr 0x1000,0x1004,0x1008,0x100C; oline_valid in cycle 5; oline=0x000000A3_000000A2_000000A1_000000A0, oline_addr=0x1000.
REQ-034 ireq_addr=0x0000_2008 -> omem_addr order 0x2008,0x200C,0x2000,0x2004; oline words placed by address, not by arrival order.
REQ-035 TIMEOUT=4, no ack on beat 2 -> after 4 wait cycles ERR, oline_valid=1,oerr=1 one cycle, omem_rd drops, obusy=0 next cycle.
REQ-036 ack arriving exactly on the TIMEOUT-th wait cycle -> no error, refill completes with oerr=0.
REQ-037 ireq pulsed during READ with different address -> ignored, oline_addr unchanged; rstn asserted after beat 2 -> no oline_valid, IDLE, all outputs 0.
